// File: rtl/serializer_pkg.sv
// Shared definitions for the word serializer and the detector-side benches.
package serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bits needed to count 0..n-1 (never less than one).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: valid/ready word input, one bit per clock out,
// with a one-word holding register for gapless back-to-back streaming.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             FRAME_START,
  output logic             FRAME_END
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             hf_q, hf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] s_shifted;

  assign accept   = DIN_VALID && !hf_q;
  assign last_bit = (cnt_q == CntLast);

  // The bit on SOUT is always at the output end; shift the next one into it.
  always_comb begin
    if (MSB_FIRST) begin
      s_shifted = {s_q[WIDTH-2:0], 1'b0};
    end else begin
      s_shifted = {1'b0, s_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    h_d     = h_q;
    hf_d    = hf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          s_d     = DIN;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          s_d   = s_shifted;
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            h_d  = DIN;
            hf_d = 1'b1;
          end
        end else if (hf_q) begin
          s_d   = h_q;
          hf_d  = 1'b0;
          cnt_d = '0;
        end else if (accept) begin
          // Empty holding register: load straight into the shifter, no gap.
          s_d   = DIN;
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      h_q     <= '0;
      hf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      h_q     <= h_d;
      hf_q    <= hf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DIN_READY   = !hf_q;
  assign SVALID      = (state_q == ST_SHIFT);
  assign SOUT        = SVALID && (MSB_FIRST ? s_q[WIDTH-1] : s_q[0]);
  assign FRAME_START = SVALID && (cnt_q == '0);
  assign FRAME_END   = SVALID && last_bit;

endmodule
